// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and read/write encodings for the RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: combinational winner select between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN selects alternation on a tie; otherwise data always beats fetch.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic   f_req,
    input  logic   d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic   last_fetch,
`endif
    output owner_t win
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign win = (f_req && d_req) ? (last_fetch ? OWN_DATA : OWN_FETCH) :
                 d_req ? OWN_DATA : f_req ? OWN_FETCH : OWN_NONE;
`else
    assign win = d_req ? OWN_DATA : f_req ? OWN_FETCH : OWN_NONE;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and data path.
// MEM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking; default build is data-over-fetch priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_enable,
    output logic              mem_read_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic [1:0]        owner
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d, win;
    logic [2:0]        cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              f_done_q, f_done_d;
    logic              d_done_q, d_done_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
    always_comb ptr_d = (state_q == ST_DONE) ? (owner_q == OWN_FETCH) : ptr_q;
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 1'b1;
        else       ptr_q <= ptr_d;
    end
    mem_arb_picker u_picker (.f_req(f_req), .d_req(d_req), .last_fetch(ptr_q), .win(win));
`else
    mem_arb_picker u_picker (.f_req(f_req), .d_req(d_req), .win(win));
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        f_done_d  = 1'b0;
        d_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win != OWN_NONE) begin
                    state_d = ST_ACCESS;
                    owner_d = win;
                    cnt_d   = 3'(MEM_LAT);
                    en_d    = 1'b1;
                    rw_d    = (win == OWN_FETCH) ? RW_READ : d_rw;
                    addr_d  = (win == OWN_FETCH) ? f_addr : d_addr;
                    wdata_d = (win == OWN_FETCH) ? wdata_q : d_wdata;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd1) begin
                    state_d   = ST_DONE;
                    en_d      = 1'b0;
                    f_rdata_d = (rw_q == RW_READ && owner_q == OWN_FETCH) ? mem_data_out : f_rdata_q;
                    d_rdata_d = (rw_q == RW_READ && owner_q == OWN_DATA) ? mem_data_out : d_rdata_q;
                    f_done_d  = (owner_q == OWN_FETCH);
                    d_done_d  = (owner_q == OWN_DATA);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            rw_q      <= RW_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            f_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            f_done_q  <= f_done_d;
            d_done_q  <= d_done_d;
        end
    end

    assign mem_enable     = en_q;
    assign mem_read_write = rw_q;
    assign mem_address    = addr_q;
    assign mem_data_in    = wdata_q;
    assign f_rdata        = f_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign f_done         = f_done_q;
    assign d_done         = d_done_q;
    assign busy           = (state_q != ST_IDLE);
    assign owner          = owner_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port RAM (16-bit address, 32-bit data, read_write=1 read / 0 write) between two requesters: the state-machine instruction fetch (read-only) and the memory access block data path (read/write).
- Sits between state_machine / memory_access_block and memory.
- Sequences each RAM access through an IDLE / ACCESS / DONE state machine with a req/done handshake per requester.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 32, RAM data width
MEM_LAT, 1, cycles mem_enable is held before mem_data_out is captured (legal 1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
f_req  in  1  fetch request, level, held until f_done
f_addr  in  ADDR_W  fetch address (PC)
f_done  out  1  one-cycle pulse, fetch access complete
f_rdata  out  DATA_W  fetched instruction, registered
d_req  in  1  data request, level, held until d_done
d_rw  in  1  1=read, 0=write (RAM encoding)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_done  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  data read result, registered
mem_enable  out  1  RAM enable
mem_read_write  out  1  RAM read_write
mem_address  out  ADDR_W  RAM address
mem_data_in  out  DATA_W  RAM write data
mem_data_out  in  DATA_W  RAM read data
busy  out  1  high whenever state is not IDLE
owner  out  2  0=none, 1=fetch, 2=data

Behaviour:
- Reset, taking effect on the next clk edge:
  - state=IDLE, owner=0, busy=0, mem_enable=0.
  - mem_read_write=1 (safe read).
  - mem_address, mem_data_in, f_rdata and d_rdata = 0.
  - f_done=0, d_done=0; round-robin pointer = fetch-last.
- IDLE:
  - Samples f_req and d_req at each edge.
  - If either is high, it latches the winner's addr, rw and wdata into the mem_* registers, sets owner, loads the latency counter with MEM_LAT, and moves to ACCESS.
  - A fetch access always drives mem_read_write=1.
- ACCESS:
  - mem_enable=1 for exactly MEM_LAT cycles; mem_* outputs are held stable.
  - On the last ACCESS cycle edge, a read captures mem_data_out into f_rdata or d_rdata (by owner).
  - A write captures nothing; the rdata registers hold their previous value.
  - Then moves to DONE.
- DONE:
  - mem_enable=0; the owner's done pulses for exactly one cycle.
  - The pointer is updated to the owner; owner returns to 0 on exit.
  - Always returns to IDLE; there is no back-to-back issue from DONE.
- Latency and throughput:
  - If req is sampled at edge E0, done is high in cycle MEM_LAT+1 after E0.
  - One access per MEM_LAT+2 cycles.
- Handshake:
  - The requester must drop req in the IDLE cycle following done. If req is still high when IDLE samples it, that is a new request.
  - If req drops mid-access, the access still completes and done still pulses.
  - Changes to addr/wdata after grant are ignored (values are latched).
- Simultaneous f_req and d_req in IDLE: the winner per the arbitration policy (see Optional Feature).
- The non-winner stays pending and no done is issued to it. It is granted in the next IDLE if still requesting.
- f_rdata and d_rdata are independent and hold until that owner's next read.
- f_done and d_done are never high in the same cycle.
- Reset mid-operation: the access is aborted at that edge; no done; mem_enable=0 on the following cycle.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie, the requester not granted last wins (alternation).
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, data always beats fetch. The pointer register is omitted.
- Single-requester behaviour is identical in both builds.

Decomposition:
- mem_arb_pkg holds:
  - state encoding ST_IDLE=0, ST_ACCESS=1, ST_DONE=2;
  - owner codes OWN_NONE=0, OWN_FETCH=1, OWN_DATA=2;
  - RW_READ=1, RW_WRITE=0.
- Sub-module mem_arb_picker: combinational winner select from (f_req, d_req, pointer). It contains the only macro-dependent logic.

Test Plan:
- Reset, then f_req, f_addr=0x0003, RAM[3]=0x06180038, MEM_LAT=1 -> mem_enable high 1 cycle, f_done in cycle 2 after sampling, f_rdata=0x06180038, d_done stays 0.
- d_req, d_rw=0, d_addr=0x0016, d_wdata=0x00000005 -> mem_read_write=0, mem_address=0x0016, RAM[22]=5 afterwards, d_done pulse, d_rdata unchanged.
- f_req and d_req raised in the same cycle, both held for 4 accesses -> fixed build: D,D,D,D (fetch starved while d_req is held); MEM_ARB_ROUND_ROBIN_EN build: D,F,D,F.
- MEM_LAT=3, data read of RAM[23]=0x0000000C -> mem_enable high 3 cycles, d_done 4 cycles after sampling, d_rdata=0x0000000C.
- reset asserted during the 2nd ACCESS cycle of a MEM_LAT=3 read -> no done, mem_enable=0 and owner=0 next cycle, d_rdata=0.
- f_req held high through f_done -> a second fetch starts from IDLE; busy low for exactly one cycle between the accesses.
